// File: rtl/rr_priority_encoder.sv
// Priority encoder with a valid/ready handshake and one result register.
// MODE=0 picks the lowest set request bit; MODE=1 searches round-robin from a rotating pointer.
module rr_priority_encoder #(
  parameter int N = 8,
  parameter int MODE = 0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_none,
  output logic         out_multi
);

  localparam int W1 = W + 1;

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_bits(input logic [N-1:0] v);
    logic [N-1:0] rest;
    rest = v & (v - {{(N-1){1'b0}}, 1'b1});
    return |rest;
  endfunction

  logic         out_valid_r;
  logic [W-1:0] out_idx_r;
  logic [N-1:0] out_onehot_r;
  logic         out_none_r;
  logic         out_multi_r;
  logic [W-1:0] ptr_r;

  logic         capture_s;
  logic         found_s;
  logic [W-1:0] win_idx_s;
  logic [N-1:0] onehot_s;
  logic [W-1:0] ptr_nxt_s;
  logic [W1-1:0] pos_s;

  assign in_ready  = !out_valid_r || out_ready;
  assign capture_s = in_valid && in_ready;

  // Winner search, one-hot decode and next round-robin pointer
  always_comb begin
    found_s   = 1'b0;
    win_idx_s = {W{1'b0}};
    onehot_s  = {N{1'b0}};
    ptr_nxt_s = ptr_r;
    pos_s     = {W1{1'b0}};
    for (int k = 32'sd0; k < N; k++) begin
      if (MODE == 32'sd1) begin
        // Search starts at ptr and wraps at N, which need not be a power of two.
        pos_s = {1'b0, ptr_r} + W1'(k);
        if (pos_s >= W1'(N)) begin
          pos_s = pos_s - W1'(N);
        end else begin
          pos_s = pos_s;
        end
      end else begin
        pos_s = W1'(k);
      end
      if (!found_s && req[pos_s[W-1:0]]) begin
        found_s   = 1'b1;
        win_idx_s = pos_s[W-1:0];
      end else begin
        found_s   = found_s;
        win_idx_s = win_idx_s;
      end
    end
    if (found_s) begin
      onehot_s[win_idx_s] = 1'b1;
    end else begin
      onehot_s = {N{1'b0}};
    end
    if (found_s && (W1'(win_idx_s) == W1'(N - 32'sd1))) begin
      ptr_nxt_s = {W{1'b0}};
    end else if (found_s) begin
      ptr_nxt_s = win_idx_s + W'(1'b1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Result register and round-robin pointer; reset wins over a simultaneous capture
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_idx_r    <= {W{1'b0}};
      out_onehot_r <= {N{1'b0}};
      out_none_r   <= 1'b0;
      out_multi_r  <= 1'b0;
      ptr_r        <= {W{1'b0}};
    end else if (capture_s) begin
      out_valid_r  <= 1'b1;
      out_idx_r    <= win_idx_s;
      out_onehot_r <= onehot_s;
      out_none_r   <= !found_s;
      out_multi_r  <= multi_bits(req);
      if ((MODE == 32'sd1) && found_s) begin
        ptr_r <= ptr_nxt_s;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_idx    = out_idx_r;
  assign out_onehot = out_onehot_r;
  assign out_none   = out_none_r;
  assign out_multi  = out_multi_r;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench: three encoder instances (N=8 fixed, N=8 round-robin, N=6 round-robin)
// share one stimulus stream; a reference model queues expected results, a monitor compares.
module tb_rr_priority_encoder;

  typedef struct {
    int         idx;
    logic [7:0] oh;
    bit         none;
    bit         multi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] req;

  logic       irdy0, ov0, none0, multi0;
  logic [2:0] idx0;
  logic [7:0] oh0;
  logic       irdy1, ov1, none1, multi1;
  logic [2:0] idx1;
  logic [7:0] oh1;
  logic       irdy2, ov2, none2, multi2;
  logic [2:0] idx2;
  logic [5:0] oh2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   ptr1, ptr2;
  bit   mvalid;
  bit   checking;
  int   errors;
  int   checks;

  always #5 clk = ~clk;

  rr_priority_encoder #(.N(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_ready(irdy0),
    .out_valid(ov0), .out_ready(out_ready), .out_idx(idx0), .out_onehot(oh0),
    .out_none(none0), .out_multi(multi0));

  rr_priority_encoder #(.N(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_ready(irdy1),
    .out_valid(ov1), .out_ready(out_ready), .out_idx(idx1), .out_onehot(oh1),
    .out_none(none1), .out_multi(multi1));

  rr_priority_encoder #(.N(6), .MODE(1)) u2 (
    .clk(clk), .rst(rst), .req(req[5:0]), .in_valid(in_valid), .in_ready(irdy2),
    .out_valid(ov2), .out_ready(out_ready), .out_idx(idx2), .out_onehot(oh2),
    .out_none(none2), .out_multi(multi2));

  // Reference: scan n positions starting at the pointer (or 0), count set bits.
  function automatic exp_t ref_model(input logic [7:0] r, input int n, input int mode,
                                     input int ptr);
    exp_t e;
    int   winner;
    int   cnt;
    int   pos;
    winner = -1;
    cnt    = 0;
    for (int k = 0; k < n; k++) begin
      pos = (mode == 1) ? (ptr + k) % n : k;
      if (r[k]) cnt++;
      if (winner < 0 && r[pos]) winner = pos;
    end
    e.none  = (winner < 0);
    e.idx   = e.none ? 0 : winner;
    e.oh    = e.none ? 8'h00 : (8'h01 << winner);
    e.multi = (cnt >= 2);
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic [2:0] idx,
                     input logic [7:0] oh, input logic none, input logic multi);
    checks++;
    if (int'(idx) !== e.idx || oh !== e.oh || none !== e.none || multi !== e.multi) begin
      errors++;
      $display("FAIL %s t=%0t: got idx=%0d oh=%h none=%b multi=%b, want idx=%0d oh=%h none=%b multi=%b",
               nm, $time, idx, oh, none, multi, e.idx, e.oh, e.none, e.multi);
    end
  endtask

  task automatic cmp_bit(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t: got %b, want %b", nm, $time, got, want);
    end
  endtask

  // Reference model: tracks handshake and pointers, queues expected results on capture
  initial begin
    bit   cap;
    exp_t e;
    ptr1   = 0;
    ptr2   = 0;
    mvalid = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q0.delete();
        q1.delete();
        q2.delete();
        ptr1   = 0;
        ptr2   = 0;
        mvalid = 1'b0;
      end else begin
        cap = in_valid && (!mvalid || out_ready);
        if (cap) begin
          q0.push_back(ref_model(req, 8, 0, 0));
          e = ref_model(req, 8, 1, ptr1);
          q1.push_back(e);
          if (!e.none) ptr1 = (e.idx + 1) % 8;
          e = ref_model(req & 8'h3F, 6, 1, ptr2);
          q2.push_back(e);
          if (!e.none) ptr2 = (e.idx + 1) % 6;
          mvalid = 1'b1;
        end else if (out_ready) begin
          mvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: compares whatever the DUTs present, pops on consumption
  initial begin
    forever begin
      @(negedge clk);
      if (checking && !rst) begin
        cmp_bit("in_ready0", irdy0, !mvalid || out_ready);
        cmp_bit("in_ready1", irdy1, !mvalid || out_ready);
        cmp_bit("in_ready2", irdy2, !mvalid || out_ready);
        cmp_bit("out_valid0", ov0, mvalid);
        cmp_bit("out_valid1", ov1, mvalid);
        cmp_bit("out_valid2", ov2, mvalid);
        if (mvalid) begin
          cmp_bit("queue_nonempty", (q0.size() > 0) && (q1.size() > 0) && (q2.size() > 0), 1'b1);
          if (q0.size() > 0) begin
            cmp("m0_fixed", q0[0], idx0, oh0, none0, multi0);
            if (out_ready) void'(q0.pop_front());
          end
          if (q1.size() > 0) begin
            cmp("m1_rr8", q1[0], idx1, oh1, none1, multi1);
            if (out_ready) void'(q1.pop_front());
          end
          if (q2.size() > 0) begin
            cmp("m2_rr6", q2[0], idx2, {2'b00, oh2}, none2, multi2);
            if (out_ready) void'(q2.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input bit v, input bit rdy, input logic [7:0] r);
    in_valid  = v;
    out_ready = rdy;
    req       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse(input bit v, input logic [7:0] r);
    rst      = 1'b1;
    in_valid = v;
    req      = r;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    checking  = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    req       = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    checking = 1'b1;

    // Reset state and in_ready right after reset
    cyc(0, 0, 8'h00);
    cmp_bit("reset_out_valid", ov0, 1'b0);
    cmp_bit("reset_in_ready", irdy0, 1'b1);

    // Lowest index with two bits set
    cyc(1, 1, 8'b0010_1000);
    cyc(0, 1, 8'h00);

    // Round-robin walk over a full request vector
    rst_pulse(0, 8'h00);
    for (int i = 0; i < 9; i++) cyc(1, 1, 8'hFF);
    cyc(0, 1, 8'h00);

    // Non-power-of-two wrap: drive N=6 pointer to 5 then wrap both ways
    rst_pulse(0, 8'h00);
    cyc(1, 1, 8'h10);
    cyc(1, 1, 8'h01);
    cyc(1, 1, 8'h20);
    cyc(1, 1, 8'h3F);

    // Zero request is delivered and leaves the pointer alone
    cyc(1, 1, 8'h00);
    cyc(1, 1, 8'hFF);
    cyc(0, 1, 8'h00);

    // Backpressure: result held while out_ready=0, then replaced without a bubble
    cyc(1, 1, 8'h44);
    cyc(1, 0, 8'h81);
    cyc(1, 0, 8'h18);
    cyc(1, 0, 8'hC0);
    cyc(1, 1, 8'h02);
    cyc(0, 1, 8'h00);

    // Reset with a pending result and pointer at 4, capture requested in the same cycle
    rst_pulse(0, 8'h00);
    cyc(1, 1, 8'h08);
    cyc(1, 0, 8'h01);
    rst_pulse(1, 8'hFF);
    cyc(0, 0, 8'h00);
    cmp_bit("rst_discard", ov1, 1'b0);
    cyc(1, 1, 8'hFF);
    cyc(0, 1, 8'h00);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst_pulse($urandom_range(0, 1) == 1, 8'($urandom));
      end else begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
      end
    end
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
